// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with a shadowed display frame.
// Each digit slot opens with a dead window (all anodes off) before the digit is driven.
module seven_seg_scanner #(
   parameter int NUM_DIGITS   = 8,
   parameter int DIGIT_CYCLES = 1024,
   parameter int DEAD_CYCLES  = 16,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] i_value,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic [NUM_DIGITS-1:0]   i_blank,
   input  logic                    i_load,
   output logic [NUM_DIGITS-1:0]   o_anode,
   output logic [6:0]              o_seg,
   output logic                    o_dp,
   output logic                    o_frame
);

   localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0]         CNT_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0]         CNT_DEAD = CW'(DEAD_CYCLES);
   localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ANODE_POL = {NUM_DIGITS{ACTIVE_LOW}};
   localparam logic [6:0]            SEG_POL   = {7{ACTIVE_LOW}};

   typedef enum logic [0:0] {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

   // Active-high segment pattern, bit order gfedcba.
   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         4'hF:    seg = 7'h71;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   state_t                  state_r, state_nxt_s;
   logic [CW-1:0]           cnt_r, cnt_nxt_s;
   logic [IW-1:0]           idx_r, idx_nxt_s;
   logic                    slot_end_s, frame_end_s;
   logic [4*NUM_DIGITS-1:0] shd_val_r, dsp_val_r, dsp_val_nxt_s;
   logic [NUM_DIGITS-1:0]   shd_dp_r, dsp_dp_r, dsp_dp_nxt_s;
   logic [NUM_DIGITS-1:0]   shd_blank_r, dsp_blank_r, dsp_blank_nxt_s;
   logic [NUM_DIGITS-1:0]   anode_hi_s, anode_nxt_s;
   logic [6:0]              seg_hi_s, seg_nxt_s;
   logic [3:0]              nib_s;
   logic                    dp_hi_s, dp_nxt_s, frame_nxt_s;

   // State, scan position, shadow and display registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_BLANK;
         cnt_r       <= '0;
         idx_r       <= '0;
         shd_val_r   <= '0;
         shd_dp_r    <= '0;
         shd_blank_r <= '0;
         dsp_val_r   <= '0;
         dsp_dp_r    <= '0;
         dsp_blank_r <= '0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         idx_r       <= idx_nxt_s;
         dsp_val_r   <= dsp_val_nxt_s;
         dsp_dp_r    <= dsp_dp_nxt_s;
         dsp_blank_r <= dsp_blank_nxt_s;
         if (i_load) begin
            shd_val_r   <= i_value;
            shd_dp_r    <= i_dp;
            shd_blank_r <= i_blank;
         end
      end
   end

   // Next scan position, FSM transition and frame-boundary display update.
   always_comb begin
      slot_end_s  = (cnt_r == CNT_LAST);
      frame_end_s = slot_end_s && (idx_r == IDX_LAST);
      if (slot_end_s) begin
         cnt_nxt_s = '0;
      end else begin
         cnt_nxt_s = cnt_r + CW'(1);
      end
      if (frame_end_s) begin
         idx_nxt_s = '0;
      end else if (slot_end_s) begin
         idx_nxt_s = idx_r + IW'(1);
      end else begin
         idx_nxt_s = idx_r;
      end
      case (state_r)
         ST_BLANK: state_nxt_s = (cnt_nxt_s == CNT_DEAD) ? ST_DRIVE : ST_BLANK;
         ST_DRIVE: state_nxt_s = slot_end_s ? ST_BLANK : ST_DRIVE;
         default:  state_nxt_s = ST_BLANK;
      endcase
      // A load coinciding with the boundary bypasses the shadow so it is not a frame late.
      if (frame_end_s && i_load) begin
         dsp_val_nxt_s   = i_value;
         dsp_dp_nxt_s    = i_dp;
         dsp_blank_nxt_s = i_blank;
      end else if (frame_end_s) begin
         dsp_val_nxt_s   = shd_val_r;
         dsp_dp_nxt_s    = shd_dp_r;
         dsp_blank_nxt_s = shd_blank_r;
      end else begin
         dsp_val_nxt_s   = dsp_val_r;
         dsp_dp_nxt_s    = dsp_dp_r;
         dsp_blank_nxt_s = dsp_blank_r;
      end
   end

   // Output values for the upcoming cycle, so the registered outputs track the count exactly.
   always_comb begin
      nib_s = dsp_val_nxt_s[{idx_nxt_s, 2'b00} +: 4];
      if (state_nxt_s == ST_DRIVE) begin
         anode_hi_s = dsp_blank_nxt_s[idx_nxt_s] ? '0 : (NUM_DIGITS'(1) << idx_nxt_s);
         seg_hi_s   = hex_decode(nib_s);
         dp_hi_s    = dsp_dp_nxt_s[idx_nxt_s];
      end else begin
         anode_hi_s = '0;
         seg_hi_s   = 7'h00;
         dp_hi_s    = 1'b0;
      end
      frame_nxt_s = (idx_nxt_s == IDX_LAST) && (cnt_nxt_s == CNT_LAST);
      anode_nxt_s = anode_hi_s ^ ANODE_POL;
      seg_nxt_s   = seg_hi_s ^ SEG_POL;
      dp_nxt_s    = dp_hi_s ^ ACTIVE_LOW;
   end

   // Registered board outputs; reset forces everything dark.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_anode <= ANODE_POL;
         o_seg   <= SEG_POL;
         o_dp    <= ACTIVE_LOW;
         o_frame <= 1'b0;
      end else begin
         o_anode <= anode_nxt_s;
         o_seg   <= seg_nxt_s;
         o_dp    <= dp_nxt_s;
         o_frame <= frame_nxt_s;
      end
   end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexed seven-segment display driver. Shows processor debug values (PC, register contents) on the board's common-anode hex display.
- It is the board-output counterpart of the switch input path. Board switches are debounced into the core; this block drives the core's values out to the display.
- Values load through a one-cycle strobe and are shadowed, so the displayed frame never tears mid-scan.

Parameters:
- NUM_DIGITS, 8: number of digits scanned; also the anode bus width.
- DIGIT_CYCLES, 1024: clock cycles per digit slot (dead time plus drive time). Legal range: > DEAD_CYCLES.
- DEAD_CYCLES, 16: cycles at the start of each slot with all anodes inactive (ghosting suppression). Legal range: >= 1.
- ACTIVE_LOW, 1: 1 means a lit segment or enabled anode is driven 0; 0 means driven 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- i_value  input  4*NUM_DIGITS  hex nibbles. Nibble k (bits 4k+3:4k) goes to digit k; digit 0 is rightmost.
- i_dp  input  NUM_DIGITS  decimal point request per digit.
- i_blank  input  NUM_DIGITS  per-digit blank request (anode kept inactive).
- i_load  input  1  one-cycle strobe. Captures i_value, i_dp and i_blank into the shadow register.
- o_anode  output  NUM_DIGITS  digit enables, polarity per ACTIVE_LOW.
- o_seg  output  7  segments. Bit 0 is a, bit 6 is g. Polarity per ACTIVE_LOW.
- o_dp  output  1  decimal point, polarity per ACTIVE_LOW.
- o_frame  output  1  one-cycle pulse on the last cycle of each full scan.

Behaviour:
- **Clock and reset:** one clock domain. Reset is asynchronous and active-low, named rst_n; clock is clk. All inputs are synchronous to clk and are not resynchronised.
- **Reset values:**
  - o_anode all inactive; o_seg all unlit; o_dp unlit; o_frame 0.
  - Shadow and display registers 0; blank bits 0.
  - Digit index 0; slot counter 0; state BLANK.
- **Registers:**
  - Shadow register (value, dp, blank) loads on any cycle with i_load=1.
  - Display register copies shadow at the frame boundary, i.e. the cycle o_frame=1.
  - If i_load=1 in the frame-boundary cycle, display takes the incoming i_load data directly (bypass), and shadow also takes it.
- **State machine:** two states, BLANK and DRIVE.
  - Slot counter width is $clog2(DIGIT_CYCLES). It counts 0..DIGIT_CYCLES-1 within a slot.
  - Cycle 0 is the first rising edge after rst_n deasserts.
  - BLANK covers counts 0..DEAD_CYCLES-1. All anodes inactive, segments unlit, dp unlit.
  - DRIVE covers counts DEAD_CYCLES..DIGIT_CYCLES-1:
    - anode[idx] active unless display blank[idx]=1;
    - o_seg = hex decode of display nibble idx;
    - o_dp = display dp[idx].
  - At count DIGIT_CYCLES-1, the counter wraps to 0, the FSM goes to BLANK, and idx increments. idx wraps NUM_DIGITS-1 -> 0.
- **Outputs:** all registered. Each output reflects the current count/state in the same cycle; there is no extra pipeline stage. Exactly zero or one anode is active in any cycle.
- **o_frame:** 1 exactly when idx=NUM_DIGITS-1 and count=DIGIT_CYCLES-1. New display data appears from digit 0 of the next frame.
- **Hex decode (active-high form, bits gfedcba):**
  - 0=3F 1=06 2=5B 3=4F
  - 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C
  - C=39 d=5E E=79 F=71
  - When ACTIVE_LOW=1, o_seg, o_dp and o_anode are bitwise inverted.
- **Reset mid-scan:** outputs return to reset values immediately (asynchronously). The scan restarts at digit 0, count 0. Shadow contents are lost.
- **i_load while idle:** i_load held high for multiple cycles recaptures every cycle; only the last value before the boundary is displayed.

Test Plan:
All scenarios use NUM_DIGITS=4, DIGIT_CYCLES=8, DEAD_CYCLES=2, ACTIVE_LOW=1.

1. Reset then release, no load -> cycles 0-1: o_anode=4'b1111. Cycles 2-7: o_anode=4'b1110, o_seg=7'b1000000 ("0"). o_frame high only at cycle 31, then every 32 cycles.
2. i_load with i_value=16'h1A3F, i_dp=0, i_blank=0 at cycle 5 -> digits keep showing 0 until cycle 32. Cycles 34-39: anode 1110, seg ~7'h71 ("F"). Cycles 42-47: anode 1101, seg ~7'h4F ("3"). Then digit 2 shows ~7'h77 ("A") and digit 3 shows ~7'h06 ("1").
3. i_load at cycle 31 (frame boundary) with i_value=16'h0008 -> digit 0 shows ~7'h7F ("8") from cycle 34, with no one-frame delay.
4. i_blank=4'b0010 and i_dp=4'b0100 loaded -> during digit 1's DRIVE window o_anode=4'b1111. During digit 2's window o_dp=0 (lit); o_dp=1 elsewhere.
5. Assert rst_n=0 mid-DRIVE on digit 2 -> o_anode=4'b1111 and o_seg=7'h7F in the same cycle, without waiting for a clock. After release, scan resumes at digit 0, count 0, showing "0".
6. Every cycle, check: popcount of active anodes <= 1, and no anode is active in counts 0-1 of any slot.
